// File: rtl/bpu_pkg.sv
// Shared types and counter helpers for the branch prediction unit and its BTB.
// Entry fields are sized for the widest supported configuration; unused upper bits stay zero.
package bpu_pkg;

  localparam int TAG_MAX_W = 32;
  localparam int CTR_MAX_W = 8;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    ctr_t                 ctr;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic ctr_t CTR_MAX(input int ctrW);
    return ctr_t'((1 << ctrW) - 1);
  endfunction

  function automatic ctr_t CTR_WT(input int ctrW);
    return ctr_t'(1 << (ctrW - 1));
  endfunction

  function automatic ctr_t CTR_WNT(input int ctrW);
    return ctr_t'((1 << (ctrW - 1)) - 1);
  endfunction

  // Saturating up/down step of a ctrW-bit direction counter.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken, input int ctrW);
    ctr_t result;
    result = ctr;
    if (taken) begin
      if (ctr != CTR_MAX(ctrW)) result = ctr + ctr_t'(1);
    end else begin
      if (ctr != '0) result = ctr - ctr_t'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational fetch read, EX-side read for read-modify-write,
// and one synchronous write port with reset clear.
module btb_table
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rdIdx,
  output btb_entry_t       o_rdEntry,
  input  logic [IDX_W-1:0] i_exIdx,
  output btb_entry_t       o_exEntry,
  input  logic             i_wrEn,
  input  logic [IDX_W-1:0] i_wrIdx,
  input  btb_entry_t       i_wrEntry
);

  localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, ctr: CTR_WNT(CTR_W), target: '0};

  btb_entry_t r_mem [ENTRIES];

  // Reset wins over a pending write so an in-flight update is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= RESET_ENTRY;
    end else if (i_wrEn) begin
      r_mem[i_wrIdx] <= i_wrEntry;
    end
  end

  assign o_rdEntry = r_mem[i_rdIdx];
  assign o_exEntry = r_mem[i_exIdx];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution: BTB lookup for IF, target/redirect computation in EX,
// BTB update policy and branch/misprediction performance counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] IF_PC,
  output logic            Pred_Taken,
  output logic [31:0]     Pred_Target,
  input  logic            Ex_Valid,
  input  logic [PC_W-1:0] Ex_PC,
  input  logic [31:0]     Imm,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Jalr,
  input  logic [31:0]     AluResult,
  input  logic            Ex_PredTaken,
  input  logic [31:0]     Ex_PredTarget,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic            Redirect,
  output logic [31:0]     Redirect_PC,
  output logic [31:0]     Br_Count,
  output logic [31:0]     Mispred_Count
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] w_ifIdx, w_exIdx;
  logic [31:0]      w_ifTag, w_exTag;
  btb_entry_t       w_ifEntry, w_exEntry, w_wrEntry;
  logic             w_ifHit, w_exHit, w_wrEn, w_upd;
  logic [31:0]      w_exPc, w_jalrSum, w_actPc;
  logic             w_actTaken;
  logic [31:0]      r_brCount, r_mispredCount;

  // Tags are kept zero-extended to 32 bits so stored and looked-up tags compare directly.
  assign w_ifIdx = IDX_W'(IF_PC >> 2);
  assign w_exIdx = IDX_W'(Ex_PC >> 2);
  assign w_ifTag = 32'(IF_PC >> (IDX_W + 2));
  assign w_exTag = 32'(Ex_PC >> (IDX_W + 2));

  btb_table #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .i_rdIdx   (w_ifIdx),
    .o_rdEntry (w_ifEntry),
    .i_exIdx   (w_exIdx),
    .o_exEntry (w_exEntry),
    .i_wrEn    (w_wrEn),
    .i_wrIdx   (w_exIdx),
    .i_wrEntry (w_wrEntry)
  );

  assign w_ifHit     = w_ifEntry.valid && (w_ifEntry.tag == w_ifTag);
  assign Pred_Taken  = w_ifHit && (w_ifEntry.ctr >= CTR_WT(CTR_W));
  assign Pred_Target = Pred_Taken ? w_ifEntry.target : '0;

  assign w_exPc     = 32'(Ex_PC);
  assign w_jalrSum  = AluResult + Imm;
  assign PC_Imm     = Jalr ? (w_jalrSum & ~32'd1) : (w_exPc + Imm);
  assign PC_Four    = w_exPc + 32'd4;
  assign w_actTaken = (Branch && AluResult[0]) || Jump || Jalr;
  assign w_actPc    = w_actTaken ? PC_Imm : PC_Four;

  // A taken prediction with the wrong target is a misprediction just like a wrong direction.
  assign Redirect    = Ex_Valid && ((Ex_PredTaken != w_actTaken) ||
                                    (w_actTaken && (Ex_PredTarget != PC_Imm)));
  assign Redirect_PC = Ex_Valid ? w_actPc : '0;

  assign w_upd   = Ex_Valid && (Branch || Jump || Jalr);
  assign w_exHit = w_exEntry.valid && (w_exEntry.tag == w_exTag);

  // Unconditional jumps always install a strongly-taken entry; conditional branches only
  // train an existing entry, or allocate one when they turn out taken.
  always_comb begin
    w_wrEn    = 1'b0;
    w_wrEntry = w_exEntry;
    if (w_upd) begin
      if (Jump || Jalr) begin
        w_wrEn    = 1'b1;
        w_wrEntry = '{valid: 1'b1, tag: w_exTag, ctr: CTR_MAX(CTR_W), target: PC_Imm};
      end else if (w_exHit) begin
        w_wrEn        = 1'b1;
        w_wrEntry.ctr = sat_update(w_exEntry.ctr, AluResult[0], CTR_W);
        if (AluResult[0]) w_wrEntry.target = PC_Imm;
      end else if (AluResult[0]) begin
        w_wrEn    = 1'b1;
        w_wrEntry = '{valid: 1'b1, tag: w_exTag, ctr: CTR_WT(CTR_W), target: PC_Imm};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_brCount      <= '0;
      r_mispredCount <= '0;
    end else begin
      if (w_upd)    r_brCount      <= r_brCount + 32'd1;
      if (Redirect) r_mispredCount <= r_mispredCount + 32'd1;
    end
  end

  assign Br_Count      = r_brCount;
  assign Mispred_Count = r_mispredCount;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scenario-per-task bench for branch_predict_unit; expected values are queued at drive time
// and popped when the settled combinational/registered outputs are sampled.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  IF_PC;
  logic        Pred_Taken;
  logic [31:0] Pred_Target;
  logic        Ex_Valid;
  logic [8:0]  Ex_PC;
  logic [31:0] Imm;
  logic        Branch, Jump, Jalr;
  logic [31:0] AluResult;
  logic        Ex_PredTaken;
  logic [31:0] Ex_PredTarget;
  logic [31:0] PC_Imm, PC_Four;
  logic        Redirect;
  logic [31:0] Redirect_PC, Br_Count, Mispred_Count;

  logic [31:0] expQ[$];
  logic [31:0] expVal;
  int nCompared = 0;
  int nMismatched = 0;

  branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CTR_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .IF_PC         (IF_PC),
    .Pred_Taken    (Pred_Taken),
    .Pred_Target   (Pred_Target),
    .Ex_Valid      (Ex_Valid),
    .Ex_PC         (Ex_PC),
    .Imm           (Imm),
    .Branch        (Branch),
    .Jump          (Jump),
    .Jalr          (Jalr),
    .AluResult     (AluResult),
    .Ex_PredTaken  (Ex_PredTaken),
    .Ex_PredTarget (Ex_PredTarget),
    .PC_Imm        (PC_Imm),
    .PC_Four       (PC_Four),
    .Redirect      (Redirect),
    .Redirect_PC   (Redirect_PC),
    .Br_Count      (Br_Count),
    .Mispred_Count (Mispred_Count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                               input logic br, input logic jp, input logic jr,
                               input logic [31:0] alu, input logic pt, input logic [31:0] ptgt);
    Ex_Valid = v; Ex_PC = pc; Imm = imm; Branch = br; Jump = jp; Jalr = jr;
    AluResult = alu; Ex_PredTaken = pt; Ex_PredTarget = ptgt;
  endtask

  task automatic idleEx();
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; IF_PC = 9'h040; idleEx();
    repeat (2) tick();
    reset = 1'b0;
    expQ.push_back(32'd0); expQ.push_back(32'h0); expQ.push_back(32'd0);
    expQ.push_back(32'd0); expQ.push_back(32'd0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL reset_pred_taken: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Pred_Target !== expVal) begin nMismatched++; $display("[TB] FAIL reset_pred_target: got %0h want %0h", Pred_Target, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL reset_br_count: got %0h want %0h", Br_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL reset_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL reset_redirect: got %0h want %0h", Redirect, expVal); end
  endtask

  task automatic test_cold_taken();
    IF_PC = 9'h040;
    applyStimulus(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
    expQ.push_back(32'd1); expQ.push_back(32'h60); expQ.push_back(32'h60);
    expQ.push_back(32'h44); expQ.push_back(32'd0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL cold_redirect: got %0h want %0h", Redirect, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL cold_redirect_pc: got %0h want %0h", Redirect_PC, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (PC_Imm !== expVal) begin nMismatched++; $display("[TB] FAIL cold_pc_imm: got %0h want %0h", PC_Imm, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (PC_Four !== expVal) begin nMismatched++; $display("[TB] FAIL cold_pc_four: got %0h want %0h", PC_Four, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL cold_same_cycle_pred: got %0h want %0h", Pred_Taken, expVal); end
    tick();
    idleEx();
    expQ.push_back(32'd1); expQ.push_back(32'h60); expQ.push_back(32'd1); expQ.push_back(32'd1);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL cold_next_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Pred_Target !== expVal) begin nMismatched++; $display("[TB] FAIL cold_next_target: got %0h want %0h", Pred_Target, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL cold_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL cold_br_count: got %0h want %0h", Br_Count, expVal); end
  endtask

  task automatic test_hysteresis();
    IF_PC = 9'h040;
    applyStimulus(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h60);
    expQ.push_back(32'd1); expQ.push_back(32'h44);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_nt_redirect: got %0h want %0h", Redirect, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_nt_redirect_pc: got %0h want %0h", Redirect_PC, expVal); end
    tick();
    idleEx();
    expQ.push_back(32'd0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_after_nt_pred: got %0h want %0h", Pred_Taken, expVal); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 32'h60);
      expQ.push_back(32'd0);
      settle();
      expVal = expQ.pop_front(); nCompared++;
      if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_taken_redirect_%0d: got %0h want %0h", i, Redirect, expVal); end
      tick();
    end
    applyStimulus(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h60);
    expQ.push_back(32'd1);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_sat_nt_redirect: got %0h want %0h", Redirect, expVal); end
    tick();
    idleEx();
    expQ.push_back(32'd1); expQ.push_back(32'h60); expQ.push_back(32'd7); expQ.push_back(32'd3);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_saturated_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Pred_Target !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_saturated_target: got %0h want %0h", Pred_Target, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_br_count: got %0h want %0h", Br_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL hyst_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
  endtask

  task automatic test_jalr();
    IF_PC = 9'h010;
    applyStimulus(1'b1, 9'h010, 32'h4, 1'b0, 1'b0, 1'b1, 32'h101, 1'b0, 32'h0);
    expQ.push_back(32'h104); expQ.push_back(32'd1); expQ.push_back(32'h104);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (PC_Imm !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_pc_imm: got %0h want %0h", PC_Imm, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_redirect: got %0h want %0h", Redirect, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_redirect_pc: got %0h want %0h", Redirect_PC, expVal); end
    tick();
    applyStimulus(1'b1, 9'h010, 32'h4, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h104);
    expQ.push_back(32'd1); expQ.push_back(32'h104); expQ.push_back(32'd1); expQ.push_back(32'h108);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_pred_taken: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Pred_Target !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_pred_target: got %0h want %0h", Pred_Target, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_wrong_target_redirect: got %0h want %0h", Redirect, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_wrong_target_pc: got %0h want %0h", Redirect_PC, expVal); end
    tick();
    // A strongly-taken jump entry survives one not-taken branch at the same PC.
    applyStimulus(1'b1, 9'h010, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108);
    expQ.push_back(32'h14);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_nt_redirect_pc: got %0h want %0h", Redirect_PC, expVal); end
    tick();
    idleEx();
    expQ.push_back(32'd1); expQ.push_back(32'd10); expQ.push_back(32'd6);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_strong_ctr_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_br_count: got %0h want %0h", Br_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL jalr_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
  endtask

  task automatic test_alias();
    applyStimulus(1'b1, 9'h080, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
    tick();
    idleEx();
    IF_PC = 9'h040;
    expQ.push_back(32'd0); expQ.push_back(32'h0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL alias_old_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Pred_Target !== expVal) begin nMismatched++; $display("[TB] FAIL alias_old_target: got %0h want %0h", Pred_Target, expVal); end
    IF_PC = 9'h080;
    expQ.push_back(32'd1); expQ.push_back(32'hA0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL alias_new_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Pred_Target !== expVal) begin nMismatched++; $display("[TB] FAIL alias_new_target: got %0h want %0h", Pred_Target, expVal); end
    // A cold not-taken branch must not allocate an entry.
    applyStimulus(1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expQ.push_back(32'd0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL miss_nt_redirect: got %0h want %0h", Redirect, expVal); end
    tick();
    idleEx();
    IF_PC = 9'h020;
    expQ.push_back(32'd0); expQ.push_back(32'd12); expQ.push_back(32'd7);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL miss_nt_no_alloc: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL alias_br_count: got %0h want %0h", Br_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL alias_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
  endtask

  task automatic test_back_to_back();
    IF_PC = 9'h080;
    applyStimulus(1'b1, 9'h080, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA0);
    expQ.push_back(32'd1); expQ.push_back(32'd1);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL same_cycle_old_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL same_cycle_redirect: got %0h want %0h", Redirect, expVal); end
    tick();
    applyStimulus(1'b0, 9'h080, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
    expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'h0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL same_cycle_new_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL invalid_redirect: got %0h want %0h", Redirect, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL invalid_redirect_pc: got %0h want %0h", Redirect_PC, expVal); end
    tick();
    expQ.push_back(32'd0); expQ.push_back(32'd13); expQ.push_back(32'd8);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL invalid_no_update: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL invalid_br_count: got %0h want %0h", Br_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL invalid_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    applyStimulus(1'b1, 9'h080, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
    expQ.push_back(32'd1); expQ.push_back(32'hA0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Redirect) !== expVal) begin nMismatched++; $display("[TB] FAIL reset_mid_redirect: got %0h want %0h", Redirect, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Redirect_PC !== expVal) begin nMismatched++; $display("[TB] FAIL reset_mid_redirect_pc: got %0h want %0h", Redirect_PC, expVal); end
    tick();
    reset = 1'b0;
    idleEx();
    IF_PC = 9'h010;
    expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'd0);
    settle();
    expVal = expQ.pop_front(); nCompared++;
    if (32'(Pred_Taken) !== expVal) begin nMismatched++; $display("[TB] FAIL reset_mid_pred: got %0h want %0h", Pred_Taken, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Br_Count !== expVal) begin nMismatched++; $display("[TB] FAIL reset_mid_br_count: got %0h want %0h", Br_Count, expVal); end
    expVal = expQ.pop_front(); nCompared++;
    if (Mispred_Count !== expVal) begin nMismatched++; $display("[TB] FAIL reset_mid_mispred_count: got %0h want %0h", Mispred_Count, expVal); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    IF_PC = 9'h0;
    idleEx();
    test_reset();
    test_cold_taken();
    test_hysteresis();
    test_jalr();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
